register_access_sequencer: RTL

//  Initiator side of the 8x8 register bank's one-hot mask interface. Accepts one

---
 rtl/register_access_sequencer_if.sv | 39 +++
 rtl/register_access_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/register_access_sequencer_if.sv
// Bundle between the register-access sequencer and its neighbours: command in, bank masks/data, ALU operands/result.
// master = sequencer side, slave = decode/bank/ALU side.
interface register_access_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_src_a;
    logic [2:0] cmd_src_b;
    logic       cmd_imm_sel;
    logic [7:0] cmd_imm;
    logic [2:0] cmd_dst;
    logic       cmd_wr_en;
    logic [7:0] o_regmask_a;
    logic [7:0] o_regmask_b;
    logic [7:0] o_bus_a;
    logic [7:0] o_bus_b;
    logic       alu_valid;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_res_valid;
    logic [7:0] alu_res;
    logic [7:0] i_regmask;
    logic [7:0] i_bus;
    logic       setter;
    logic       done;

    modport master (
        input  cmd_valid, cmd_src_a, cmd_src_b, cmd_imm_sel, cmd_imm, cmd_dst, cmd_wr_en,
        input  o_bus_a, o_bus_b, alu_res_valid, alu_res,
        output cmd_ready, o_regmask_a, o_regmask_b, alu_valid, alu_a, alu_b,
        output i_regmask, i_bus, setter, done
    );

    modport slave (
        output cmd_valid, cmd_src_a, cmd_src_b, cmd_imm_sel, cmd_imm, cmd_dst, cmd_wr_en,
        output o_bus_a, o_bus_b, alu_res_valid, alu_res,
        input  cmd_ready, o_regmask_a, o_regmask_b, alu_valid, alu_a, alu_b,
        input  i_regmask, i_bus, setter, done
    );
endinterface

// File: rtl/register_access_sequencer.sv
// Register-transfer sequencer: reads two bank registers via one-hot masks, runs the ALU, writes the result back.
// Latency: accept->commit 3 edges best case (READ, EXEC, WRITE); done follows one cycle later. Optional REGACC_ZERO_REG_EN makes r0 read as zero and drops writes to it.
// Backpressure: cmd_ready only in IDLE; EXEC stalls indefinitely until alu_res_valid.
module register_access_sequencer (
    input  logic clk,
    input  logic rst_n,
    register_access_sequencer_if.master bus
);

`ifdef REGACC_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    logic [2:0] src_a_q;
    logic [2:0] src_b_q;
    logic [2:0] dst_q;
    logic       imm_sel_q;
    logic       wr_en_q;
    logic [7:0] imm_q;

    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [7:0] i_bus_q;
    logic       done_q;

    logic       accept;
    logic       res_take;
    logic       write_eff;
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;

    function automatic logic is_zero_reg(input logic [2:0] idx);
        return ZERO_REG && (idx == 3'd0);
    endfunction

    // A hardwired-zero r0 never gets a mask bit, on either the read or write side.
    function automatic logic [7:0] reg_mask(input logic [2:0] idx);
        return is_zero_reg(idx) ? 8'h00 : (8'h01 << idx);
    endfunction

    assign accept    = bus.cmd_valid && (state == ST_IDLE);
    assign res_take  = (state == ST_EXEC) && bus.alu_res_valid;
    assign write_eff = wr_en_q && !is_zero_reg(dst_q);

    assign opnd_a = is_zero_reg(src_a_q) ? 8'h00 : bus.o_bus_a;
    assign opnd_b = imm_sel_q ? imm_q : (is_zero_reg(src_b_q) ? 8'h00 : bus.o_bus_b);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_EXEC;
            ST_EXEC:  if (bus.alu_res_valid) state_nxt = write_eff ? ST_WRITE : ST_IDLE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            src_a_q   <= 3'd0;
            src_b_q   <= 3'd0;
            dst_q     <= 3'd0;
            imm_sel_q <= 1'b0;
            wr_en_q   <= 1'b0;
            imm_q     <= 8'h00;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            i_bus_q   <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (res_take && !write_eff) || (state == ST_WRITE);
            if (accept) begin
                src_a_q   <= bus.cmd_src_a;
                src_b_q   <= bus.cmd_src_b;
                dst_q     <= bus.cmd_dst;
                imm_sel_q <= bus.cmd_imm_sel;
                wr_en_q   <= bus.cmd_wr_en;
                imm_q     <= bus.cmd_imm;
            end
            // Bank data is combinational from the READ masks, so it is valid to sample here.
            if (state == ST_READ) begin
                alu_a_q <= opnd_a;
                alu_b_q <= opnd_b;
            end
            if (res_take) begin
                i_bus_q <= bus.alu_res;
            end
        end
    end

    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.o_regmask_a = (state == ST_READ) ? reg_mask(src_a_q) : 8'h00;
    assign bus.o_regmask_b = ((state == ST_READ) && !imm_sel_q) ? reg_mask(src_b_q) : 8'h00;
    assign bus.alu_valid   = (state == ST_EXEC);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.i_regmask   = (state == ST_WRITE) ? reg_mask(dst_q) : 8'h00;
    assign bus.i_bus       = i_bus_q;
    // Gated by rst_n so a reset landing on the WRITE cycle cannot commit.
    assign bus.setter      = (state == ST_WRITE) && rst_n;
    assign bus.done        = done_q;

    a_mask_a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.o_regmask_a));
    a_mask_b_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.o_regmask_b));
    a_wmask_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.i_regmask));

endmodule
